uart_tx_queue: RTL

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART transmitter through a start/busy
// handshake. Define UART_TXQ_OVF_EN to add the sticky overflow output.
module uart_tx_queue #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     tx_busy,
   output logic                     tx_start,
   output logic [WIDTH-1:0]         tx_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
`ifdef UART_TXQ_OVF_EN
   ,
   output logic                     overflow
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_C = DEPTH[AW:0];
   localparam logic [AW:0]   ONE_C  = 1;
   localparam logic [AW-1:0] ONE_P  = 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   state_t           state_q;
   state_t           state_d;
   logic [1:0]       to_q;
   logic [1:0]       to_d;
   logic             push_ok;
   logic             pop;

   assign full    = (count == FULL_C);
   assign empty   = (count == '0);
   assign push_ok = push && !full;

   // Storage array; contents survive reset
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers, occupancy and the launched byte
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         tx_data <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + ONE_P;
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + ONE_P;
            tx_data <= mem[rd_ptr];
         end
         case ({push_ok, pop})
            2'b10:   count <= count + ONE_C;
            2'b01:   count <= count - ONE_C;
            default: count <= count;
         endcase
      end
   end

`ifdef UART_TXQ_OVF_EN
   // Sticky record of any write dropped because the queue was full
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (push && full) begin
         overflow <= 1'b1;
      end
   end
`endif

   // Handshake FSM state and lost-handshake timer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         to_q    <= to_d;
      end
   end

   // Next-state, pop decision and launch pulse
   always_comb begin
      state_d  = state_q;
      to_d     = '0;
      pop      = 1'b0;
      tx_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty && !tx_busy) begin
               pop     = 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            tx_start = 1'b1;
            state_d  = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // four cycles without busy: give up waiting, byte counts as sent
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (to_q == 2'd3) begin
               state_d = IDLE;
            end else begin
               to_d = to_q + 2'd1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
